// File: rtl/ad7771_pkg.sv
//------------------------------------------------------------------------------
// Module : ad7771_pkg
// Brief  : Shared types and AD7771 frame layout constants for the DOUT reader.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ad7771_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int HDR_BITS    = 8;
    localparam int DATA_BITS   = 24;
    localparam int SLOT_BITS   = 32;
    localparam int NUM_CH      = 8;

    // Header layout: bit 7 = ADC error, bits [6:4] = channel ID
    localparam int HDR_ERR_BIT = 7;
    localparam int HDR_ID_LSB  = 4;
    localparam int HDR_ID_W    = 3;

endpackage : ad7771_pkg

`default_nettype wire

// File: rtl/ad7771_pin_sync.sv
//------------------------------------------------------------------------------
// Module : ad7771_pin_sync
// Brief  : Multi-flop synchroniser for one asynchronous pin with edge detect.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ad7771_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    // Stage SYNC_STAGES-2 is the newer sample, SYNC_STAGES-1 the older one
    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    assign o_fall = ~r_sync[SYNC_STAGES-2] &  r_sync[SYNC_STAGES-1];

endmodule : ad7771_pin_sync

`default_nettype wire

// File: rtl/ad7771_dout_multi_reader.sv
//------------------------------------------------------------------------------
// Module : ad7771_dout_multi_reader
// Brief  : N-lane AD7771 DOUT deframer publishing all 8 channels per frame.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ad7771_dout_multi_reader
    import ad7771_pkg::*;
#(
    parameter int NUM_LANES      = 2,
    parameter int CH_PER_LANE    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          drdy_i,
    input  logic                          dclk_i,
    input  logic [NUM_LANES-1:0]          dout_i,
    output logic [NUM_CH*DATA_BITS-1:0]   data_o,
    output logic [NUM_CH*HDR_BITS-1:0]    header_o,
    output logic                          valid_o,
    output logic                          adc_err_o,
    output logic                          id_err_o,
    output logic                          frame_err_o
);

    localparam int c_FRAME_BITS = CH_PER_LANE * SLOT_BITS;
    localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);
    localparam int c_TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_FRAME_BITS - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic                 w_drdy_sync, w_drdy_rise, w_drdy_fall;
    logic                 w_dclk_sync, w_dclk_rise, w_dclk_fall;
    logic [NUM_LANES-1:0] w_dout_sync, w_dout_rise, w_dout_fall;
    logic                 w_unused_pins;

    ad7771_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_drdy (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .i_pin    (drdy_i),
        .o_sync   (w_drdy_sync),
        .o_rise   (w_drdy_rise),
        .o_fall   (w_drdy_fall)
    );

    ad7771_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_dclk (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .i_pin    (dclk_i),
        .o_sync   (w_dclk_sync),
        .o_rise   (w_dclk_rise),
        .o_fall   (w_dclk_fall)
    );

    // Same depth as DCLK so each data bit lines up with its detected edge
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_dout_sync
        ad7771_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dout (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .i_pin    (dout_i[l]),
            .o_sync   (w_dout_sync[l]),
            .o_rise   (w_dout_rise[l]),
            .o_fall   (w_dout_fall[l])
        );
    end

    assign w_unused_pins = ^{w_drdy_sync, w_drdy_rise, w_dclk_sync, w_dclk_rise,
                             w_dout_rise, w_dout_fall};

    state_e                                   r_state, w_state_nxt;
    logic [c_CNT_W-1:0]                       r_bit_cnt;
    logic [c_TO_W-1:0]                        r_to_cnt;
    logic [NUM_LANES-1:0][c_FRAME_BITS-1:0]   r_shift;
    logic                                     w_cnt_clr, w_shift_en, w_to_inc, w_frame_err;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new /DRDY always wins over a pending final edge or timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_to_inc    = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_drdy_fall) begin
                    w_state_nxt = SHIFT;
                    w_cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (w_drdy_fall) begin
                    w_frame_err = 1'b1;
                    w_cnt_clr   = 1'b1;
                end else if (w_dclk_fall) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = DONE;
                    end
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_frame_err = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
        end else if (w_cnt_clr) begin
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            r_to_cnt  <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                r_shift[l] <= {r_shift[l][c_FRAME_BITS-2:0], w_dout_sync[l]};
            end
        end else if (w_to_inc) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    logic [NUM_CH*DATA_BITS-1:0] w_data_all;
    logic [NUM_CH*HDR_BITS-1:0]  w_hdr_all;
    logic                        w_adc_err, w_id_err;

    // Slot 0 arrives first, so it ends up in the top bits of each lane's register
    always_comb begin
        w_data_all = '0;
        w_hdr_all  = '0;
        w_adc_err  = 1'b0;
        w_id_err   = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int s = 0; s < CH_PER_LANE; s++) begin
                w_hdr_all[(l*CH_PER_LANE+s)*HDR_BITS +: HDR_BITS] =
                    r_shift[l][c_FRAME_BITS-1-s*SLOT_BITS -: HDR_BITS];
                w_data_all[(l*CH_PER_LANE+s)*DATA_BITS +: DATA_BITS] =
                    r_shift[l][c_FRAME_BITS-1-HDR_BITS-s*SLOT_BITS -: DATA_BITS];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            w_adc_err = w_adc_err | w_hdr_all[c*HDR_BITS+HDR_ERR_BIT];
            w_id_err  = w_id_err |
                (w_hdr_all[c*HDR_BITS+HDR_ID_LSB +: HDR_ID_W] != HDR_ID_W'(c));
        end
    end

    logic [NUM_CH*DATA_BITS-1:0] r_data;
    logic [NUM_CH*HDR_BITS-1:0]  r_header;
    logic                        r_valid, r_adc_err, r_id_err, r_frame_err;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_data      <= '0;
            r_header    <= '0;
            r_valid     <= 1'b0;
            r_adc_err   <= 1'b0;
            r_id_err    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= (r_state == DONE);
            r_frame_err <= w_frame_err;
            if (r_state == DONE) begin
                r_data    <= w_data_all;
                r_header  <= w_hdr_all;
                r_adc_err <= w_adc_err;
                r_id_err  <= w_id_err;
            end
        end
    end

    assign data_o      = r_data;
    assign header_o    = r_header;
    assign valid_o     = r_valid;
    assign adc_err_o   = r_adc_err;
    assign id_err_o    = r_id_err;
    assign frame_err_o = r_frame_err;

endmodule : ad7771_dout_multi_reader

`default_nettype wire

// File: doc/ad7771_dout_multi_reader.md
Name: ad7771_dout_multi_reader

Overview:
Parametrised successor to the single-lane AD7771 DOUT reader. Receives N parallel DOUT lanes from the AD7771 (ADC is master: /DRDY, DCLK, DOUTx) and deframes every 32-bit channel slot into an 8-bit header and 24-bit two's-complement sample. Publishes all channels simultaneously with a one-cycle valid strobe. Adds header channel-ID checking, mid-frame abort detection and a DCLK stall timeout. Sits between the ADC pins and the DSP/streaming path.

Parameters:
NUM_LANES, 2, number of DOUT lines used (1, 2, 4 or 8)
CH_PER_LANE, 4, channel slots per lane per frame; NUM_LANES*CH_PER_LANE must equal 8
SYNC_STAGES, 2, synchroniser depth for drdy/dclk/dout (>=2)
TIMEOUT_CYCLES, 1024, clk_i cycles without a DCLK falling edge before a frame is aborted

Ports:
clk_i  in  1  FPGA clock; must be >= 4x DCLK
reset_ni  in  1  asynchronous active-low reset
drdy_i  in  1  /DRDY pin, asynchronous
dclk_i  in  1  DCLK pin, asynchronous
dout_i  in  NUM_LANES  DOUTx pins, bit l = lane l
data_o  out  8*24  samples; channel c at [c*24 +: 24]
header_o  out  8*8  headers; channel c at [c*8 +: 8]
valid_o  out  1  one-cycle pulse: data_o/header_o updated
adc_err_o  out  1  OR of header bit 7 over all channels, latched with valid_o
id_err_o  out  1  latched with valid_o: any header[6:4] != expected ID
frame_err_o  out  1  one-cycle pulse: frame aborted (mid-frame /DRDY fall or timeout)

Behaviour:
- Reset (async assert, sync release by the async flop set): state IDLE, counters 0, shift registers 0, all outputs 0, sync stages 1 for drdy/dclk (inactive-high idle), 0 for dout.
- All pins pass through SYNC_STAGES flops; dout uses same depth as dclk so data and edge stay aligned. Edge detect on the last two sync stages.
- Frame bit count FRAME_BITS = CH_PER_LANE*32; counter width $clog2(FRAME_BITS+1).
- IDLE: on /DRDY falling edge -> SHIFT, bit counter 0, timeout counter 0.
- SHIFT: on each DCLK falling edge, shift every lane's synchronised dout bit in MSB-first; bit counter +1; timeout counter cleared. Otherwise timeout counter +1.
  - Counter reaches FRAME_BITS -> DONE.
  - /DRDY falling edge in SHIFT -> frame_err_o pulse, restart SHIFT with counters 0 (new frame wins; old data discarded).
  - Timeout counter == TIMEOUT_CYCLES-1 -> frame_err_o pulse, -> IDLE.
  - /DRDY falling edge and final DCLK edge in same cycle: abort-and-restart takes priority.
- DONE (one cycle): lane l, slot s (slot 0 sent first) -> channel c = l*CH_PER_LANE + s; header = slot bits [31:24], data = [23:0]. Register data_o, header_o, adc_err_o, id_err_o (expected ID = c[2:0]); valid_o=1 next cycle. -> IDLE.
- Latency: valid_o asserts 2 clk_i cycles after the cycle in which the final DCLK falling edge is detected (DONE + output register).
- data_o/header_o/error flags hold until next valid_o; no output on aborted frames.
- valid_o and frame_err_o never high in the same cycle.
- DCLK edges in IDLE ignored.

Decomposition:
- Package ad7771_pkg: state enum (IDLE, SHIFT, DONE), HDR_BITS=8, DATA_BITS=24, SLOT_BITS=32, NUM_CH=8, header field positions (ERR bit 7, ID [6:4]).
- Sub-module ad7771_pin_sync: SYNC_STAGES-deep synchroniser with rise/fall detect outputs, instantiated per pin (drdy, dclk, each dout lane).

Test Plan:
- Default params, DCLK = clk/8, lane0 slots headers 0x00,0x10,0x20,0x30 data 0x000001..0x000004, lane1 headers 0x40..0x70 data 0x800000..0x800003 -> one valid_o; data_o ch0=0x000001, ch4=0x800000, ch7=0x800003; id_err_o=0, adc_err_o=0.
- Same frame with ch5 header 0xD0 (err bit set, ID 5) -> adc_err_o=1, id_err_o=0; ch3 header 0x20 instead -> id_err_o=1.
- /DRDY falls again after 40 of 128 DCLK edges, then full frame -> one frame_err_o pulse, exactly one valid_o with second frame's data.
- DCLK stops after 10 edges -> frame_err_o pulse at TIMEOUT_CYCLES, no valid_o, state IDLE; next full frame decodes correctly.
- reset_ni pulsed low mid-frame (async, not clock-aligned) -> all outputs 0 immediately; next frame decodes correctly.
- NUM_LANES=8, CH_PER_LANE=1 and NUM_LANES=1, CH_PER_LANE=8 with channel c data = 0x100000*c+c -> identical data_o in both configurations.
